// File: rtl/vga_pkg.sv
// Shared VGA constants (640x480@60 timing), capture FSM state and helpers.
package vga_pkg;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam int CNT_W   = 10;

  // bit positions of the three edge-detected control inputs
  localparam int SIG_HS  = 0;
  localparam int SIG_VS  = 1;
  localparam int SIG_VLD = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Single-bit input register with rise/fall pulses against its previous value.
module vga_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic q_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      q_q    <= d_i;
      prev_q <= q_q;
    end
  end

  assign q_o    = q_q;
  assign rise_o = q_q & ~prev_q;
  assign fall_o = ~q_q & prev_q;

endmodule

// File: rtl/vga_capture.sv
// VGA pixel capture with frame timing check and SEARCH/ARMED/LOCKED tracking.
// Define VGA_CAPTURE_CKSUM_EN to add the per-frame pixel checksum output frame_sum.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACT,
  parameter int V_ACTIVE = V_ACT
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        locked,
  output logic        frame_done,
  output logic        err
`ifdef VGA_CAPTURE_CKSUM_EN
  ,output logic [23:0] frame_sum
`endif
);

  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACTIVE);

  logic [2:0] sig_in, sig_q, sig_rise, sig_fall;

  assign sig_in[SIG_HS]  = hsync;
  assign sig_in[SIG_VS]  = vsync;
  assign sig_in[SIG_VLD] = valid;

  for (genvar i = 0; i < 3; i++) begin : g_edge
    vga_edge_det u_edge (
      .clk_i (pclk),
      .rst_ni(reset),
      .d_i   (sig_in[i]),
      .q_o   (sig_q[i]),
      .rise_o(sig_rise[i]),
      .fall_o(sig_fall[i])
    );
  end

  logic hs_q, vs_q, vld_q, vs_fall, vld_rise, vld_fall;
  assign hs_q     = sig_q[SIG_HS];
  assign vs_q     = sig_q[SIG_VS];
  assign vld_q    = sig_q[SIG_VLD];
  assign vs_fall  = sig_fall[SIG_VS];
  assign vld_rise = sig_rise[SIG_VLD];
  assign vld_fall = sig_fall[SIG_VLD];

  logic [23:0] rgb_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) rgb_q <= '0;
    else        rgb_q <= {vga_r, vga_g, vga_b};
  end

  cap_state_e       state_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, cur_x;
  logic             ferr_q, ferr_d;
  logic             in_range, capture, drop, line_bad, sync_viol, frame_good;

  always_comb begin
    // the first pixel of a line is x=0 even though x_q still holds the previous count
    cur_x      = vld_rise ? '0 : x_q;
    in_range   = (cur_x < H_LIM) && (y_q < V_LIM);
    capture    = vld_q && in_range && (state_q != SEARCH);
    drop       = vld_q && !in_range;
    line_bad   = vld_fall && (x_q != H_LIM);
    // any sync activity during active video, incl. vsync falling with valid high
    sync_viol  = vld_q && (!hs_q || !vs_q || (|sig_rise[1:0]) || (|sig_fall[1:0]));
    frame_good = (y_q == V_LIM) && !ferr_q && !line_bad && !sync_viol;
    x_d        = vld_q ? sat_inc(cur_x) : x_q;
    y_d        = vld_fall ? sat_inc(y_q) : y_q;
    ferr_d     = ferr_q | drop | line_bad | sync_viol;
    if (vs_fall) begin
      x_d    = '0;
      y_d    = '0;
      ferr_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      ferr_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ferr_q <= ferr_d;
    end
  end

  logic [9:0]  pix_x_q, pix_y_q;
  logic [23:0] pix_data_q;
  logic        pix_valid_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= capture;
      if (capture) begin
        pix_x_q    <= cur_x;
        pix_y_q    <= y_q;
        pix_data_q <= rgb_q;
      end
    end
  end

`ifdef VGA_CAPTURE_CKSUM_EN
  logic [23:0] sum_acc_q, frame_sum_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset)       sum_acc_q <= '0;
    else if (vs_fall) sum_acc_q <= '0;
    else if (capture) sum_acc_q <= sum_acc_q + rgb_q;
  end

  assign frame_sum = frame_sum_q;
`endif

  logic locked_q, done_q, err_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef VGA_CAPTURE_CKSUM_EN
      frame_sum_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (vs_fall) begin
        case (state_q)
          SEARCH: state_q <= ARMED;
          ARMED: begin
            if (frame_good) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_good) begin
              done_q      <= 1'b1;
`ifdef VGA_CAPTURE_CKSUM_EN
              frame_sum_q <= sum_acc_q;
`endif
            end else begin
              state_q  <= ARMED;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign locked     = locked_q;
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 8x6 raster to keep runs short.
module tb_vga_capture;

  localparam int H = 8;
  localparam int V = 6;

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic        pix_valid, locked, frame_done, err;
`ifdef VGA_CAPTURE_CKSUM_EN
  logic [23:0] frame_sum;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .valid     (valid),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .locked    (locked),
    .frame_done(frame_done),
    .err       (err)
`ifdef VGA_CAPTURE_CKSUM_EN
    ,.frame_sum(frame_sum)
`endif
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [9:0] x; logic [9:0] y; logic [23:0] d; } pix_t;
  typedef struct { int cyc; int kind; logic [23:0] sum; } ev_t;  // 1 done, 2 err, 3 lock on, 4 lock off

  pix_t pq[$];
  ev_t  eq[$];
  int   checks = 0, errors = 0;

  // reference view of the capture state, advanced at each driven vsync fall
  int          m_st = 0, m_lines = 0;
  bit          m_bad = 1'b0;
  logic [23:0] m_sum = '0;
  logic        prev_lk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic v, input logic [23:0] rgb);
    hsync = hs; vsync = vs; valid = v; {vga_r, vga_g, vga_b} = rgb;
    @(posedge pclk); #1;
  endtask

  task automatic push_ev(input int kind);
    ev_t e;
    e.cyc = cyc + 2; e.kind = kind; e.sum = m_sum;
    eq.push_back(e);
  endtask

  task automatic model_vsfall();
    bit good;
    good = !m_bad && (m_lines == V);
    case (m_st)
      0: m_st = 1;
      1: if (good) begin m_st = 2; push_ev(3); end
      default: begin
        if (good) push_ev(1);
        else begin push_ev(2); push_ev(4); m_st = 1; end
      end
    endcase
    m_bad = 1'b0; m_lines = 0; m_sum = '0;
  endtask

  task automatic line(input logic vs, input int l, input int len, input int mode);
    logic [23:0] rgb;
    step(1'b0, vs, 1'b0, '0); step(1'b0, vs, 1'b0, '0);
    step(1'b1, vs, 1'b0, '0); step(1'b1, vs, 1'b0, '0);
    for (int i = 0; i < len; i++) begin
      case (mode)
        1:       rgb = 24'hFFFFFF;
        2:       rgb = 24'h000001;
        default: rgb = {8'(i + 16), 8'(l + 32), 8'h5A};
      endcase
      if (m_st != 0 && i < H && l < V) begin
        pix_t p;
        p.cyc = cyc + 2; p.x = 10'(i); p.y = 10'(l); p.d = rgb;
        pq.push_back(p);
        m_sum = m_sum + rgb;
      end
      step(1'b1, vs, 1'b1, rgb);
    end
    for (int i = 0; i < 2 + ((len < H) ? H - len : 0); i++) step(1'b1, vs, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0; hsync = 1'b1; vsync = 1'b1; valid = 1'b0; {vga_r, vga_g, vga_b} = '0;
    #1;
    chk("reset_flags", {pix_valid, locked, frame_done, err}, 64'h0);
    chk("reset_pix", {pix_x, pix_y, pix_data}, 64'h0);
    pq.delete(); eq.delete();
    m_st = 0; m_bad = 1'b0; m_lines = 0; m_sum = '0;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  // frame starts with its vsync fall; rst_line >= 0 aborts the frame with a reset
  task automatic frame(input int nlines, input int bad_line, input int bad_len,
                       input int mode, input int rst_line);
    int len;
    model_vsfall();
    line(1'b0, -1, 0, 0);
    line(1'b1, -1, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      if (l == rst_line) begin
        do_reset();
        return;
      end
      len = (l == bad_line) ? bad_len : H;
      if (len != H || l >= V) m_bad = 1'b1;
      m_lines++;
      line(1'b1, l, len, mode);
    end
    line(1'b1, -1, 0, 0);
  endtask

  task automatic chk_ev(input int kind);
    ev_t e;
    if (eq.size() == 0) begin
      checks++; errors++;
      $display("FAIL event_unexpected: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = eq.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
`ifdef VGA_CAPTURE_CKSUM_EN
      if (kind == 1) chk("frame_sum", 64'(frame_sum), 64'(e.sum));
`endif
    end
  endtask

  always @(negedge pclk) begin
    if (!reset) prev_lk = 1'b0;
    else begin
      if (pix_valid) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d data=%h expected none", pix_x, pix_y, pix_data);
        end else begin
          pix_t p;
          p = pq.pop_front();
          chk("pix_xy_data", 64'({pix_x, pix_y, pix_data}), 64'({p.x, p.y, p.d}));
          chk("pix_latency", 64'(cyc), 64'(p.cyc));
        end
      end
      if (frame_done) chk_ev(1);
      if (err)        chk_ev(2);
      if (locked !== prev_lk) chk_ev(locked ? 3 : 4);
      prev_lk = locked;
    end
  end

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk("por_flags", {pix_valid, locked, frame_done, err}, 64'h0);
    chk("por_pix", {pix_x, pix_y, pix_data}, 64'h0);
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);

    frame(V, -1, H, 0, -1);          // SEARCH -> ARMED
    frame(V, -1, H, 0, -1);          // lock on 2nd vsync fall
    chk("locked_after_two_falls", 64'(locked), 64'h1);
    frame(V, -1, H, 1, -1);          // frame_done; white pixels
    frame(V, -1, H, 2, -1);          // done; all-ones-LSB pixels
    frame(V, 2, H - 1, 0, -1);       // done carries sum; short line inside
`ifdef VGA_CAPTURE_CKSUM_EN
    chk("frame_sum_8x6", 64'(frame_sum), 64'h30);
`endif
    frame(V, -1, H, 0, -1);          // err, unlock
    chk("unlocked_short_line", 64'(locked), 64'h0);
    frame(V + 1, -1, H, 0, -1);      // relock; then one line too many
    frame(V, -1, H, 0, -1);          // err, unlock
    chk("unlocked_long_frame", 64'(locked), 64'h0);
    frame(V, -1, H, 0, 2);           // relock, then reset mid-frame
    frame(V, -1, H, 0, -1);          // SEARCH -> ARMED
    chk("locked_low_one_fall", 64'(locked), 64'h0);
    frame(V, -1, H, 0, -1);          // lock
    chk("relocked_after_reset", 64'(locked), 64'h1);
    frame(V, -1, H, 0, -1);          // frame_done
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);

    chk("pix_queue_drained", 64'(pq.size()), 64'h0);
    chk("event_queue_drained", 64'(eq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
